// File: rtl/context_switch_unit.sv
// Saves the live register image of the resident task and replays the target
// task's saved registers into the register file, one register per cycle.
module context_switch_unit #(
   parameter int NUM_TASKS = 4,
   parameter int TASK_W    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              switch_req,
   input  logic [TASK_W-1:0] next_task,
   input  logic [31:0]       pc_in,
   input  logic [991:0]      all_reg_data,
   output logic              context_switch_active,
   output logic [4:0]        context_switch_count,
   output logic [31:0]       switching_data,
   output logic              busy,
   output logic              done,
   output logic [31:0]       restore_pc,
   output logic [TASK_W-1:0] cur_task
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int NUM_WORDS = 32;
   localparam int PC_WORD   = 31;
   localparam logic [4:0] LAST_REG = 5'd31;

   state_t            state_q;
   logic [TASK_W-1:0] target_q;
   logic [TASK_W-1:0] cur_q;
   logic [4:0]        count_q;
   logic              busy_q;
   logic              active_q;
   logic              done_q;

   // Word k holds x(k+1) for k = 0..30; word 31 holds the saved PC.
   logic [31:0]       ctx_mem [NUM_TASKS][NUM_WORDS];
   logic [4:0]        word_idx;

   assign word_idx = count_q - 5'd1;

   // NOTE: the context store is reset on purpose: a never-saved slot must
   // restore zeros, so this storage cannot be mapped onto an un-resettable RAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int t = 0; t < NUM_TASKS; t++) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
               ctx_mem[t][w] <= '0;
            end
         end
      end else if (state_q == SAVE) begin
         for (int w = 0; w < PC_WORD; w++) begin
            ctx_mem[cur_q][w] <= all_reg_data[w*32 +: 32];
         end
         ctx_mem[cur_q][PC_WORD] <= pc_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         target_q <= '0;
         cur_q    <= '0;
         count_q  <= 5'd1;
         busy_q   <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (switch_req) begin
                  target_q <= next_task;
                  busy_q   <= 1'b1;
                  if (next_task != cur_q) begin
                     state_q <= SAVE;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            SAVE: begin
               count_q  <= 5'd1;
               active_q <= 1'b1;
               state_q  <= RESTORE;
            end
            RESTORE: begin
               // count_q stays in 1..31, so x0 is never addressed.
               if (count_q == LAST_REG) begin
                  active_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  count_q <= count_q + 5'd1;
               end
            end
            DONE: begin
               cur_q   <= target_q;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy                  = busy_q;
   assign done                  = done_q;
   assign cur_task              = cur_q;
   assign context_switch_active = active_q;
   assign context_switch_count  = active_q ? count_q : 5'd0;
   assign switching_data        = active_q ? ctx_mem[target_q][word_idx] : 32'd0;
   assign restore_pc            = done_q ? ctx_mem[target_q][PC_WORD] : 32'd0;

endmodule

// File: tb/tb_context_switch_unit.sv
// Directed bench for context_switch_unit: a table of switches with
// hand-computed restore data, plus reset-abort and same-task sequences.
module tb_context_switch_unit;

   localparam int NUM_TASKS = 4;
   localparam int TASK_W    = 2;

   logic              clk;
   logic              reset;
   logic              switch_req;
   logic [TASK_W-1:0] next_task;
   logic [31:0]       pc_in;
   logic [991:0]      all_reg_data;
   logic              context_switch_active;
   logic [4:0]        context_switch_count;
   logic [31:0]       switching_data;
   logic              busy;
   logic              done;
   logic [31:0]       restore_pc;
   logic [TASK_W-1:0] cur_task;

   int checks = 0;
   int errors = 0;

   context_switch_unit #(.NUM_TASKS(NUM_TASKS), .TASK_W(TASK_W)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .switch_req            (switch_req),
      .next_task             (next_task),
      .pc_in                 (pc_in),
      .all_reg_data          (all_reg_data),
      .context_switch_active (context_switch_active),
      .context_switch_count  (context_switch_count),
      .switching_data        (switching_data),
      .busy                  (busy),
      .done                  (done),
      .restore_pc            (restore_pc),
      .cur_task              (cur_task)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [TASK_W-1:0] next_task;
      logic [31:0]       reg_base;  // x_i = reg_base + i at save time
      logic [31:0]       pc;
      bit                same;      // request targets the resident task
      bit                noise;     // pulse switch_req with other IDs while busy
      logic [31:0]       exp_base;  // restored x_i = exp_base + i, 0 => all zero
      logic [31:0]       exp_pc;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [991:0] build_regs(input logic [31:0] base);
      logic [991:0] r;
      for (int i = 1; i <= 31; i++) r[(i-1)*32 +: 32] = base + 32'(i);
      return r;
   endfunction

   // One complete switch, observed for 36 cycles after the request edge.
   task automatic apply(input vec_t v);
      int done_cnt, done_cyc, busy_cnt, act_cnt, zero_idx, idle_bad, rpc_bad;
      logic [31:0] exp_data;
      done_cnt = 0; done_cyc = 0; busy_cnt = 0; act_cnt = 0;
      zero_idx = 0; idle_bad = 0; rpc_bad = 0;
      @(negedge clk);
      all_reg_data = build_regs(v.reg_base);
      pc_in        = v.pc;
      next_task    = v.next_task;
      switch_req   = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 36; c++) begin
         #1;
         if (busy) busy_cnt++;
         if (context_switch_active) begin
            act_cnt++;
            if (context_switch_count == 5'd0) zero_idx++;
         end else if (context_switch_count != 5'd0 || switching_data != 32'd0) begin
            idle_bad++;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
            check("restore_pc", restore_pc, v.exp_pc);
            check("active_in_done", 32'(context_switch_active), 32'd0);
         end else if (restore_pc != 32'd0) begin
            rpc_bad++;
         end
         if (!v.same && c == 1) begin
            check("save_busy", 32'(busy), 32'd1);
            check("save_active", 32'(context_switch_active), 32'd0);
         end
         if (!v.same && c >= 2 && c <= 32) begin
            exp_data = (v.exp_base == 32'd0) ? 32'd0 : v.exp_base + 32'(c - 1);
            check("restore_active", 32'(context_switch_active), 32'd1);
            check("restore_count", 32'(context_switch_count), 32'(c - 1));
            check("switching_data", switching_data, exp_data);
         end
         @(negedge clk);
         if (v.noise && c >= 2 && c <= 28) begin
            switch_req = c[0];
            next_task  = v.next_task + 2'd1;
         end else begin
            switch_req = 1'b0;
            next_task  = v.next_task;
         end
         @(posedge clk);
      end
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("done_cycle", 32'(done_cyc), v.same ? 32'd1 : 32'd33);
      check("busy_cycles", 32'(busy_cnt), v.same ? 32'd1 : 32'd33);
      check("active_cycles", 32'(act_cnt), v.same ? 32'd0 : 32'd31);
      check("x0_written", 32'(zero_idx), 32'd0);
      check("idle_port_nonzero", 32'(idle_bad), 32'd0);
      check("restore_pc_outside_done", 32'(rpc_bad), 32'd0);
      #1;
      check("cur_task", 32'(cur_task), 32'(v.next_task));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_active"}, 32'(context_switch_active), 32'd0);
      check({tag, "_count"}, 32'(context_switch_count), 32'd0);
      check({tag, "_data"}, switching_data, 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_restore_pc"}, restore_pc, 32'd0);
      check({tag, "_cur_task"}, 32'(cur_task), 32'd0);
   endtask

   initial begin
      vec_t vecs [10];
      vec_t v;
      bit   hit;

      // Slot contents tracked by hand: each switch saves into the resident slot.
      vecs[0] = '{2'd1, 32'h100, 32'h400, 1'b0, 1'b0, 32'h000, 32'h000};
      vecs[1] = '{2'd0, 32'h200, 32'h500, 1'b0, 1'b0, 32'h100, 32'h400};
      vecs[2] = '{2'd2, 32'h300, 32'h600, 1'b0, 1'b0, 32'h000, 32'h000};
      vecs[3] = '{2'd2, 32'h000, 32'h000, 1'b1, 1'b0, 32'h000, 32'h000};
      vecs[4] = '{2'd3, 32'h700, 32'h800, 1'b0, 1'b1, 32'h000, 32'h000};
      vecs[5] = '{2'd0, 32'h900, 32'hA00, 1'b0, 1'b0, 32'h300, 32'h600};
      vecs[6] = '{2'd2, 32'hB00, 32'hC00, 1'b0, 1'b0, 32'h700, 32'h800};
      vecs[7] = '{2'd2, 32'h000, 32'h000, 1'b1, 1'b0, 32'h000, 32'h800};
      vecs[8] = '{2'd3, 32'hD00, 32'hE00, 1'b0, 1'b0, 32'h900, 32'hA00};
      vecs[9] = '{2'd1, 32'hF00, 32'hF10, 1'b0, 1'b1, 32'h200, 32'h500};

      reset        = 1'b0;
      switch_req   = 1'b0;
      next_task    = '0;
      pc_in        = '0;
      all_reg_data = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;

      for (int i = 0; i < 10; i++) apply(vecs[i]);

      // Abort a switch mid-restore with an asynchronous reset.
      @(negedge clk);
      all_reg_data = build_regs(32'h1234_0000);
      pc_in        = 32'hCAFE;
      next_task    = 2'd2;
      switch_req   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      switch_req = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(posedge clk);
         #1;
         if (context_switch_active && context_switch_count == 5'd10) hit = 1'b1;
      end
      check("reached_count_10", 32'(hit), 32'd1);
      reset = 1'b0;
      #1;
      check_all_zero("abort");
      @(negedge clk);
      reset = 1'b1;

      // Slot 0 PC after reset, read through a same-task request.
      v = '{2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0};
      apply(v);
      v = '{2'd1, 32'h55, 32'h66, 1'b0, 1'b0, 32'h0, 32'h0};
      apply(v);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
